// File: rtl/instr_fetch_if.sv
// Bundle between the fetch unit, instruction memory (imem*), the branch unit
// (redirect*) and the decode stage (instr*).
interface instr_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemData;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPC;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instrReady;
  logic        misaligned;

  modport master (
    output imemReq, imemAddr,
    input  imemAck, imemData,
    input  redirect, redirectPC,
    output instrValid, instr, instrPC, opcode, funct,
    input  instrReady,
    output misaligned
  );

  modport slave (
    input  imemReq, imemAddr,
    output imemAck, imemData,
    output redirect, redirectPC,
    input  instrValid, instr, instrPC, opcode, funct,
    output instrReady,
    input  misaligned
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: one outstanding imem request, DEPTH-entry prefetch queue.
// Define FETCH_ALIGN_CHECK_EN to flag misaligned redirect targets instead of truncating them.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   addr_reg, addr_next;
  logic          pending_reg, pending_next;
  logic          squash_reg, squash_next;
  logic          misaligned_reg, misaligned_next;
  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   word_mem [DEPTH];

  logic          ack_fire;
  logic          push;
  logic          pop;
  logic          target_bad;
  logic [31:0]   target_pc;
  logic [31:0]   head_word;

`ifdef FETCH_ALIGN_CHECK_EN
  assign target_bad = (bus.redirectPC[1:0] != 2'b00);
  assign target_pc  = bus.redirectPC;
`else
  assign target_bad = 1'b0;
  assign target_pc  = {bus.redirectPC[31:2], 2'b00};
`endif

  always_comb begin
    ack_fire        = pending_reg & bus.imemAck;
    pop             = (count_reg != '0) & bus.instrReady;
    // A response is only kept if it was not squashed and no redirect flushes it now.
    push            = ack_fire & ~squash_reg & ~bus.redirect;
    fetch_pc_next   = fetch_pc_reg;
    addr_next       = addr_reg;
    pending_next    = pending_reg;
    squash_next     = squash_reg;
    misaligned_next = misaligned_reg;
    head_next       = head_reg;
    tail_next       = tail_reg;
    count_next      = count_reg;

    if (bus.redirect) begin
      head_next       = '0;
      tail_next       = '0;
      count_next      = '0;
      fetch_pc_next   = target_pc;
      misaligned_next = target_bad;
      squash_next     = pending_reg & ~bus.imemAck;
    end else begin
      if (push) begin
        tail_next     = tail_reg + 1'b1;
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (pop) begin
        head_next = head_reg + 1'b1;
      end
      count_next = count_reg + CW'(push) - CW'(pop);
      if (ack_fire) begin
        squash_next = 1'b0;
      end
    end

    // Issue only when the next response is guaranteed a free slot.
    if (!pending_reg || bus.imemAck) begin
      pending_next = (count_next < CW'(DEPTH)) & ~misaligned_next;
      addr_next    = fetch_pc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg   <= RESET_PC;
      addr_reg       <= RESET_PC;
      pending_reg    <= 1'b0;
      squash_reg     <= 1'b0;
      misaligned_reg <= 1'b0;
      head_reg       <= '0;
      tail_reg       <= '0;
      count_reg      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]   <= '0;
        word_mem[i] <= '0;
      end
    end else begin
      fetch_pc_reg   <= fetch_pc_next;
      addr_reg       <= addr_next;
      pending_reg    <= pending_next;
      squash_reg     <= squash_next;
      misaligned_reg <= misaligned_next;
      head_reg       <= head_next;
      tail_reg       <= tail_next;
      count_reg      <= count_next;
      if (push) begin
        pc_mem[tail_reg]   <= addr_reg;
        word_mem[tail_reg] <= bus.imemData;
      end
    end
  end

  assign head_word      = word_mem[head_reg];
  assign bus.imemReq    = pending_reg;
  assign bus.imemAddr   = addr_reg;
  assign bus.instrValid = (count_reg != '0);
  assign bus.instr      = head_word;
  assign bus.instrPC    = pc_mem[head_reg];
  assign bus.opcode     = head_word[31:26];
  assign bus.funct      = head_word[5:0];
  assign bus.misaligned = misaligned_reg;
endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: memory model acks requests and pushes the
// expected {pc, word}; decode-side deliveries are popped and compared.
module tb_instr_fetch;
  logic clk;
  logic rst_n;

  instr_fetch_if bus();

  instr_fetch #(
    .RESET_PC(32'h0000_3000),
    .DEPTH   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ent_t;

  ent_t        sb[$];
  logic [31:0] exp_addr;
  logic [31:0] drop_addr;
  bit          drop_next;
  bit          use_table;
  int          n_checks;
  int          n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] word_for(input logic [31:0] addr);
    if (use_table && addr == 32'h3000) return 32'h012A_4020;
    if (use_table && addr == 32'h3004) return 32'h2128_FFFF;
    return addr;
  endfunction

  // Called just after a rising edge; drives this cycle's inputs and advances one cycle.
  task automatic cyc(input bit ack_en, input bit redir, input logic [31:0] target);
    ent_t e;
    check_val("instrValid", bus.instrValid, sb.size() != 0);
    if (sb.size() != 0) begin
      check_val("instrPC", bus.instrPC, sb[0].pc);
      check_val("instr", bus.instr, sb[0].word);
      if (bus.instrReady) begin
        $display("deliver pc=0x%08h instr=0x%08h", bus.instrPC, bus.instr);
        void'(sb.pop_front());
      end
    end
    bus.imemAck  = 1'b0;
    bus.imemData = '0;
    if (bus.imemReq && ack_en) begin
      bus.imemAck = 1'b1;
      if (drop_next) begin
        check_val("squashAddr", bus.imemAddr, drop_addr);
        bus.imemData = 32'hDEAD_BEEF;
        drop_next    = 1'b0;
      end else begin
        check_val("imemAddr", bus.imemAddr, exp_addr);
        bus.imemData = word_for(exp_addr);
        if (!redir) begin
          e.pc   = exp_addr;
          e.word = bus.imemData;
          sb.push_back(e);
        end
        exp_addr = exp_addr + 32'd4;
      end
    end
    bus.redirect   = redir;
    bus.redirectPC = target;
    if (redir) begin
      sb.delete();
      if (bus.imemReq && !ack_en) begin
        if (!drop_next) drop_addr = exp_addr;
        drop_next = 1'b1;
      end
`ifdef FETCH_ALIGN_CHECK_EN
      exp_addr = target;
`else
      exp_addr = {target[31:2], 2'b00};
`endif
    end
    @(posedge clk);
    #1;
    bus.redirect = 1'b0;
    bus.imemAck  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    #1;
    rst_n          = 1'b0;
    bus.imemAck    = 1'b0;
    bus.imemData   = '0;
    bus.redirect   = 1'b0;
    bus.redirectPC = '0;
    bus.instrReady = 1'b0;
    use_table      = 1'b0;
    #1;
    check_val("rst_imemReq", bus.imemReq, 32'd0);
    check_val("rst_instrValid", bus.instrValid, 32'd0);
    check_val("rst_instr", bus.instr, 32'd0);
    check_val("rst_instrPC", bus.instrPC, 32'd0);
    check_val("rst_misaligned", bus.misaligned, 32'd0);
    sb.delete();
    exp_addr  = 32'h3000;
    drop_next = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_val("rel_imemReq", bus.imemReq, 32'd1);
    check_val("rel_imemAddr", bus.imemAddr, 32'h3000);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Zero-wait memory, decode always ready: one fetch and one delivery per cycle.
    do_reset();
    bus.instrReady = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_val("stream_imemReq", bus.imemReq, 32'd1);
      cyc(1'b1, 1'b0, '0);
    end

    // Decode stalled: queue fills to DEPTH and requests stop, then drains in order.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, '0);
    check_val("full_imemReq", bus.imemReq, 32'd0);
    bus.instrReady = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, '0);

    // Ack delayed by two cycles: request held stable.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check_val("hold_imemReq", bus.imemReq, 32'd1);
      check_val("hold_imemAddr", bus.imemAddr, 32'h3000);
      cyc(i == 2, 1'b0, '0);
    end
    cyc(1'b0, 1'b0, '0);
    check_val("after_ack_addr", bus.imemAddr, 32'h3004);

    // Reset mid-transfer, then redirect while 0x3008 is outstanding.
    do_reset();
    bus.instrReady = 1'b1;
    cyc(1'b1, 1'b0, '0);
    cyc(1'b1, 1'b0, '0);
    cyc(1'b0, 1'b1, 32'h3100);
    cyc(1'b1, 1'b0, '0);
    check_val("redir_imemReq", bus.imemReq, 32'd1);
    check_val("redir_imemAddr", bus.imemAddr, 32'h3100);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0);

    // Opcode / funct split of the head word.
    do_reset();
    use_table = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, '0);
    check_val("opcode_r", bus.opcode, 32'h00);
    check_val("funct_r", bus.funct, 32'h20);
    bus.instrReady = 1'b1;
    cyc(1'b0, 1'b0, '0);
    bus.instrReady = 1'b0;
    check_val("opcode_i", bus.opcode, 32'h08);
    check_val("funct_i", bus.funct, 32'h3F);

    // Redirect to a misaligned target while the first request is acked.
    do_reset();
    bus.instrReady = 1'b1;
    cyc(1'b1, 1'b1, 32'h3102);
`ifdef FETCH_ALIGN_CHECK_EN
    check_val("mis_flag", bus.misaligned, 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_val("mis_imemReq", bus.imemReq, 32'd0);
      cyc(1'b1, 1'b0, '0);
    end
    check_val("mis_flag_hold", bus.misaligned, 32'd1);
    cyc(1'b1, 1'b1, 32'h3200);
    check_val("mis_clear", bus.misaligned, 32'd0);
    check_val("mis_imemReq2", bus.imemReq, 32'd1);
    check_val("mis_imemAddr2", bus.imemAddr, 32'h3200);
`else
    check_val("mis_flag", bus.misaligned, 32'd0);
    check_val("mis_imemReq", bus.imemReq, 32'd1);
    check_val("mis_imemAddr", bus.imemAddr, 32'h3100);
`endif
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit feeding the decode stage of the MIPS core. It holds the fetch PC and reads instruction words from instruction memory over a req/ack handshake. Fetched words are buffered in a small prefetch queue and presented to decode with valid/ready, pre-split into `opcode`/`funct` for the control decoder. A taken branch or jump redirects fetch and flushes the queue.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: fetch address after reset.
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `imemReq` out 1: fetch request valid (registered).
- `imemAddr` out 32: fetch address; word aligned, stable while `imemReq` is high and not acked.
- `imemAck` in 1: memory response; `imemData` is valid in this cycle.
- `imemData` in 32: instruction word.
- `redirect` in 1: taken branch/jump, one-cycle pulse.
- `redirectPC` in 32: target address.
- `instrValid` out 1: queue head valid.
- `instr` out 32: head instruction.
- `instrPC` out 32: address of `instr`.
- `opcode` out 6: `instr[31:26]`.
- `funct` out 6: `instr[5:0]`.
- `instrReady` in 1: decode accepts the head.
- `misaligned` out 1: misaligned redirect flag (see Configuration).

## Operation
- State:
  - `fetchPC`
  - queue of {PC, word} with head, tail, count
  - `pending` (request outstanding)
  - `squash` (discard the response of the outstanding request)
- Reset values:
  - `fetchPC`=`RESET_PC`, count=0, `pending`=0, `squash`=0.
  - `imemReq`=0, `instrValid`=0, `instr`/`instrPC`=0 (all entries cleared), `misaligned`=0.
- Issue:
  - A request is raised when not `pending` and count + (ack-completion this cycle ? 0 : `pending`) < `DEPTH`.
  - At most one request is outstanding; each accepted response reserves one queue slot.
- Handshake:
  - Once raised, `imemReq` and `imemAddr` hold until a cycle with `imemAck`=1.
  - An ack in the same cycle the request is visible completes it (zero-wait memory).
  - `imemAck` while `imemReq`=0 is ignored.
- Completion (`imemAck`, not `squash`):
  - Push {`imemAddr`, `imemData`}; `fetchPC` += 4 (wraps mod 2^32).
  - `imemReq` stays high with the next address if the issue condition still holds; this gives 1 fetch/cycle.
- Completion with `squash`: data is discarded, `squash` is cleared, and `fetchPC` is unchanged.
- Pop: `instrValid && instrReady` removes the head. Push and pop in the same cycle leave count unchanged.
- Redirect:
  - Queue is flushed (count=0) and `fetchPC` ← `redirectPC`.
  - If a request is pending and not acked this cycle, `squash` is set and the request completes at its old address.
  - If acked this cycle, the data is dropped.
  - A pop in the redirect cycle is still counted as delivered.
  - A new request to the target is issued after the pending request resolves.
- Full (count=`DEPTH`): no request is issued. Empty: `instrValid`=0.

## Timing
- Reset release: `imemReq` rises at the first rising edge after `rst_n` deasserts.
- Fetch latency: ack in cycle N → `instrValid` with that word in cycle N+1.
- Redirect latency:
  - `redirect` in cycle N with no pending request → `imemReq` to target in N+1.
  - With a pending request → target request is issued the cycle after its ack.
- `rst_n` assertion mid-transfer returns all state to reset values immediately; the outstanding memory request is abandoned.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirectPC[1:0]`≠0 flushes the queue, sets `misaligned`=1, and suppresses all new requests.
  - `misaligned` stays 1 until an aligned redirect or reset.
- Undefined:
  - `redirectPC[1:0]` is forced to 00.
  - `misaligned` is tied 0; the port remains present.

## Test plan
- Reset, memory acks every cycle with data = address:
  - `imemAddr` 0x3000, 0x3004, … on consecutive cycles.
  - `instr`/`instrPC` 0x3000 appear one cycle after the first ack; then 1 per cycle.
- `instrReady`=0, zero-wait memory:
  - Exactly 4 words are queued and `imemReq` drops.
  - Raising `instrReady` drains 0x3000–0x300C in order, then fetch resumes at 0x3010.
- Ack delayed 2 cycles: `imemAddr` 0x3000 is held stable for 3 cycles; the queue holds one entry after the ack.
- Redirect to 0x3100 while the request to 0x3008 is unacked:
  - The returned 0xDEADBEEF is discarded.
  - The next request is 0x3100, and the first delivered `instrPC` is 0x3100.
- Ack data 0x012A4020: `opcode`=0x00, `funct`=0x20. Ack data 0x2128FFFF: `opcode`=0x08.
- Redirect to 0x3102:
  - With macro: `misaligned`=1 and no further `imemReq`. A later redirect to 0x3200 clears it and fetches 0x3200.
  - Without macro: fetch at 0x3100, `misaligned`=0.
